// File: rtl/mem_wb_defs.sv
// rtl/mem_wb_defs.sv - shared state, op-type and op-code encodings for the mem/wb stage
package mem_wb_defs;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [1:0] TYPE_ALU = 2'b00;
    localparam logic [1:0] TYPE_MEM = 2'b01;

    localparam logic OP_LDR = 1'b0;
    localparam logic OP_STR = 1'b1;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - upstream op handshake, data-memory port and writeback/flag outputs
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        type_code;
    logic [3:0]        op_code;
    logic [DATA_W-1:0] alu_result;
    logic              alu_neg;
    logic              alu_zero;
    logic [DATA_W-1:0] st_data;
    logic [RD_W-1:0]   rd_idx;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              wb_valid;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              flag_n;
    logic              flag_z;
    logic              err;

    modport slave (
        input  in_valid, type_code, op_code, alu_result, alu_neg, alu_zero, st_data, rd_idx,
        input  mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output wb_valid, wb_rd, wb_data, flag_n, flag_z, err
    );

    modport master (
        output in_valid, type_code, op_code, alu_result, alu_neg, alu_zero, st_data, rd_idx,
        output mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  wb_valid, wb_rd, wb_data, flag_n, flag_z, err
    );
endinterface

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - counts cycles while run is high; expired flags the TMO_CYC-th cycle
module mem_timeout_ctr #(
    parameter int TMO_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] cnt;

    // First run cycle sees cnt==0, so expiry lands on run cycle number TMO_CYC.
    assign expired = run && (cnt == CW'(TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - ALU writeback / load-store stage; MEM_TIMEOUT_EN adds a req timeout abort
module mem_wb_stage
    import mem_wb_defs::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int RD_W    = 4,
    parameter int TMO_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_wb_stage_if.slave bus
);
    state_t            state, next_state;
    logic              accept;
    logic              wb_set, err_set, flag_load, mem_start;
    logic [DATA_W-1:0] wb_data_nxt;
    logic [RD_W-1:0]   wb_rd_nxt;
    logic [RD_W-1:0]   rd_q;
    logic              expired;
    logic              unused_op;

    assign bus.in_ready = (state == ST_IDLE);
    // Derived from state so an async reset drops the request immediately.
    assign bus.mem_req  = (state == ST_REQ);
    assign accept       = bus.in_valid && (state == ST_IDLE);
    assign unused_op    = ^bus.op_code[3:1];

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state == ST_REQ),
        .expired (expired)
    );
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_CYC > 0);
    assign expired    = 1'b0;
`endif

    always_comb begin
        next_state  = state;
        wb_set      = 1'b0;
        err_set     = 1'b0;
        flag_load   = 1'b0;
        mem_start   = 1'b0;
        wb_data_nxt = bus.alu_result;
        wb_rd_nxt   = bus.rd_idx;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.type_code == TYPE_ALU) begin
                        wb_set    = 1'b1;
                        flag_load = 1'b1;
                    end else if (bus.type_code == TYPE_MEM) begin
                        if (is_misaligned(bus.alu_result[1:0])) begin
                            err_set = 1'b1;
                        end else begin
                            mem_start  = 1'b1;
                            next_state = ST_REQ;
                        end
                    end
                end
            end
            ST_REQ: begin
                wb_data_nxt = bus.mem_rdata;
                wb_rd_nxt   = rd_q;
                // Ack takes priority over a timeout expiring in the same cycle.
                if (bus.mem_ack) begin
                    next_state = ST_IDLE;
                    wb_set     = (bus.mem_we == OP_LDR);
                end else if (expired) begin
                    next_state = ST_IDLE;
                    err_set    = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            rd_q          <= '0;
            bus.wb_valid  <= 1'b0;
            bus.wb_rd     <= '0;
            bus.wb_data   <= '0;
            bus.flag_n    <= 1'b0;
            bus.flag_z    <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state        <= next_state;
            bus.wb_valid <= wb_set;
            bus.err      <= err_set;
            if (wb_set) begin
                bus.wb_data <= wb_data_nxt;
                bus.wb_rd   <= wb_rd_nxt;
            end
            if (flag_load) begin
                bus.flag_n <= bus.alu_neg;
                bus.flag_z <= bus.alu_zero;
            end
            if (mem_start) begin
                bus.mem_addr  <= bus.alu_result[ADDR_W-1:0];
                bus.mem_we    <= (bus.op_code[0] == OP_STR);
                bus.mem_wdata <= bus.st_data;
                rd_q          <= bus.rd_idx;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage against a transaction model
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic exp_n = 1'b0;
    logic exp_z = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.DATA_W(32), .ADDR_W(32), .RD_W(4)) bus ();

    mem_wb_stage #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .RD_W    (4),
        .TMO_CYC (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_flags();
        chk("flag_n", bus.flag_n, exp_n);
        chk("flag_z", bus.flag_z, exp_z);
    endtask

    // One op from accept to completion; outcome derived from the op's architectural meaning.
    task automatic run_op(input logic [1:0] t, input logic [3:0] oc, input logic [31:0] res,
                          input logic n, input logic z, input logic [31:0] sd,
                          input logic [3:0] rd, input int dly, input logic [31:0] rdata);
        chk("in_ready_idle", bus.in_ready, 1'b1);
        bus.in_valid   = 1'b1;
        bus.type_code  = t;
        bus.op_code    = oc;
        bus.alu_result = res;
        bus.alu_neg    = n;
        bus.alu_zero   = z;
        bus.st_data    = sd;
        bus.rd_idx     = rd;
        bus.mem_ack    = 1'($urandom_range(0, 1));
        bus.mem_rdata  = $urandom;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        if (t == 2'b00) begin
            exp_n = n;
            exp_z = z;
            chk("alu_wb_valid", bus.wb_valid, 1'b1);
            chk("alu_wb_data", bus.wb_data, res);
            chk("alu_wb_rd", bus.wb_rd, rd);
            chk("alu_err", bus.err, 1'b0);
            chk("alu_mem_req", bus.mem_req, 1'b0);
        end else if (t == 2'b01 && res[1:0] != 2'b00) begin
            chk("mis_err", bus.err, 1'b1);
            chk("mis_wb_valid", bus.wb_valid, 1'b0);
            chk("mis_mem_req", bus.mem_req, 1'b0);
        end else if (t == 2'b01) begin
            chk("req_mem_req", bus.mem_req, 1'b1);
            chk("req_mem_we", bus.mem_we, oc[0]);
            chk("req_mem_addr", bus.mem_addr, res);
            chk("req_mem_wdata", bus.mem_wdata, sd);
            chk("req_wb_valid", bus.wb_valid, 1'b0);
            for (int i = 0; i <= dly; i++) begin
                if (i > 0) @(negedge clk);
                chk("hold_req", bus.mem_req, 1'b1);
                chk("hold_addr", bus.mem_addr, res);
                chk("hold_in_ready", bus.in_ready, 1'b0);
                // Decoy op offered while busy must never be taken.
                bus.in_valid   = 1'b1;
                bus.type_code  = 2'b00;
                bus.alu_result = $urandom;
                bus.alu_neg    = ~exp_n;
                bus.alu_zero   = ~exp_z;
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata;
            @(negedge clk);
            bus.mem_ack  = 1'b0;
            bus.in_valid = 1'b0;
            chk("done_mem_req", bus.mem_req, 1'b0);
            chk("done_in_ready", bus.in_ready, 1'b1);
            chk("done_wb_valid", bus.wb_valid, !oc[0]);
            chk("done_err", bus.err, 1'b0);
            if (!oc[0]) begin
                chk("ldr_wb_data", bus.wb_data, rdata);
                chk("ldr_wb_rd", bus.wb_rd, rd);
            end
        end else begin
            chk("rsv_wb_valid", bus.wb_valid, 1'b0);
            chk("rsv_err", bus.err, 1'b0);
            chk("rsv_mem_req", bus.mem_req, 1'b0);
        end
        check_flags();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        int          r;
        logic [31:0] a;

        bus.in_valid = 0; bus.type_code = 0; bus.op_code = 0; bus.alu_result = 0;
        bus.alu_neg = 0; bus.alu_zero = 0; bus.st_data = 0; bus.rd_idx = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        #12;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_wb_valid", bus.wb_valid, 1'b0);
        chk("rst_wb_data", bus.wb_data, 32'h0);
        chk("rst_err", bus.err, 1'b0);
        check_flags();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 4'h0, 32'hFFFFFFF0, 1'b1, 1'b0, 32'h0, 4'h3, 0, 32'h0);
        run_op(2'b00, 4'h0, 32'h00000001, 1'b0, 1'b0, 32'h0, 4'h1, 0, 32'h0);
        run_op(2'b00, 4'h0, 32'h00000000, 1'b0, 1'b1, 32'h0, 4'h2, 0, 32'h0);
        run_op(2'b00, 4'h0, 32'h80000000, 1'b1, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_op(2'b01, 4'h0, 32'h00000100, 1'b0, 1'b0, 32'h0, 4'h5, 2, 32'hCAFEF00D);
        run_op(2'b01, 4'h1, 32'h00000204, 1'b0, 1'b0, 32'h12345678, 4'h6, 0, 32'h0);
        run_op(2'b01, 4'h0, 32'h00000102, 1'b0, 1'b0, 32'h0, 4'h7, 0, 32'h0);
        run_op(2'b10, 4'h0, 32'h00000055, 1'b0, 1'b1, 32'h0, 4'h8, 0, 32'h0);

        // Load with no ack: times out after TMO_CYC cycles, or waits forever without the option.
        bus.in_valid = 1'b1; bus.type_code = 2'b01; bus.op_code = 4'h0;
        bus.alu_result = 32'h00000400; bus.rd_idx = 4'h9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cnt = 0;
        while (bus.mem_req && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
`ifdef MEM_TIMEOUT_EN
        chk("tmo_req_cycles", cnt, 16);
        chk("tmo_err", bus.err, 1'b1);
        chk("tmo_wb_valid", bus.wb_valid, 1'b0);
        chk("tmo_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("tmo_err_pulse", bus.err, 1'b0);
`else
        chk("notmo_req_held", cnt, 40);
        chk("notmo_err", bus.err, 1'b0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADBEEF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("notmo_wb_valid", bus.wb_valid, 1'b1);
        chk("notmo_wb_data", bus.wb_data, 32'h0BADBEEF);
`endif
        check_flags();

        // Async reset in the middle of a load.
        bus.in_valid = 1'b1; bus.type_code = 2'b01; bus.op_code = 4'h0;
        bus.alu_result = 32'h00000800; bus.rd_idx = 4'hA;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("arst_req_before", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_req", bus.mem_req, 1'b0);
        chk("arst_in_ready", bus.in_ready, 1'b1);
        exp_n = 1'b0;
        exp_z = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("arst_wb_valid", bus.wb_valid, 1'b0);
        check_flags();

        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 7));
            a = $urandom;
            if (r <= 2) begin
                run_op(2'b00, 4'($urandom), a, 1'($urandom), 1'($urandom), $urandom,
                       4'($urandom), 0, 32'h0);
            end else if (r <= 5) begin
                a[1:0] = 2'b00;
                run_op(2'b01, 4'($urandom), a, 1'($urandom), 1'($urandom), $urandom,
                       4'($urandom), int'($urandom_range(0, 5)), $urandom);
            end else if (r == 6) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
                run_op(2'b01, 4'($urandom), a, 1'($urandom), 1'($urandom), $urandom,
                       4'($urandom), 0, 32'h0);
            end else begin
                run_op(2'($urandom_range(2, 3)), 4'($urandom), a, 1'($urandom),
                       1'($urandom), $urandom, 4'($urandom), 0, 32'h0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
